// File: rtl/riskv_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riskv_wb_pkg
//  Description : Shared types and constants for the Riskv Wishbone arbiter:
//                bus widths, grant encodings and the arbiter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package riskv_wb_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;

    // Values presented on the grant output
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/riskv_wb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : riskv_wb_watchdog
//  Description : Cycle counter that flags a granted transfer which has waited
//                TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES=0 removes the counter.
//  Ports       : clk    - system clock
//                reset  - asynchronous active-low reset
//                clear  - hold count at zero (no transfer in progress)
//                enable - a transfer is granted this cycle
//                expire - this granted cycle is the last one allowed
//  Revision    : 1.0 - initial release
// ============================================================================
module riskv_wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_ok;
            assign unused_ok = ^{clk, reset, clear, enable};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] count;

            // Count value equals the number of granted cycles already elapsed,
            // so the first granted cycle sees 0 and the last sees LAST.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    count <= '0;
                end else if (clear) begin
                    count <= '0;
                end else if (enable && (count != LAST)) begin
                    count <= count + CNT_W'(1);
                end
            end

            assign expire = enable && (count == LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/riskv_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : riskv_wb_arbiter
//  Description : Two-to-one Wishbone arbiter sharing one master port between
//                the fetch (i_*) and data (d_*) masters. Grants are held for a
//                whole bus cycle, ties are round-robin, and a watchdog forces
//                an error on transfers that never terminate.
//  Ports       : clk, reset(active-low async)
//                i_*        fetch master side
//                d_*        data master side
//                m_*        shared Wishbone master port
//                grant      current owner (00 none, 01 fetch, 10 data)
//                err_count  saturating count of bus errors plus timeouts
//  Revision    : 1.0 - initial release
// ============================================================================
module riskv_wb_arbiter
    import riskv_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ERRCNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    // fetch master
    input  logic [WB_ADR_W-1:0] i_adr,
    input  logic [3:0]          i_sel,
    input  logic                i_cyc,
    input  logic                i_stb,
    output logic [WB_DAT_W-1:0] i_dat_miso,
    output logic                i_ack,
    output logic                i_err,
    // data master
    input  logic [WB_ADR_W-1:0] d_adr,
    input  logic [WB_DAT_W-1:0] d_dat_mosi,
    input  logic [3:0]          d_sel,
    input  logic                d_cyc,
    input  logic                d_stb,
    input  logic                d_we,
    output logic [WB_DAT_W-1:0] d_dat_miso,
    output logic                d_ack,
    output logic                d_err,
    // shared master port
    output logic [WB_ADR_W-1:0] m_adr,
    output logic [WB_DAT_W-1:0] m_dat_mosi,
    output logic [3:0]          m_sel,
    output logic                m_cyc,
    output logic                m_stb,
    output logic                m_we,
    input  logic [WB_DAT_W-1:0] m_dat_miso,
    input  logic                m_ack,
    input  logic                m_err,
    // status
    output logic [1:0]          grant,
    output logic [ERRCNT_W-1:0] err_count
);

    arb_state_t state;
    logic       last_d;      // 1: data master owned the most recent grant

    logic i_req, d_req;
    logic gnt_i, gnt_d, granted;
    logic owner_cyc;
    logic expire, timeout, done, err_evt;

    assign i_req   = i_cyc & i_stb;
    assign d_req   = d_cyc & d_stb;
    assign gnt_i   = (state == ST_GNT_I);
    assign gnt_d   = (state == ST_GNT_D);
    assign granted = gnt_i | gnt_d;

    assign owner_cyc = gnt_i ? i_cyc : d_cyc;

    // A real termination in the expiry cycle takes precedence over the
    // watchdog, so the forced error only fires when the slave is silent.
    assign timeout = expire & ~m_ack & ~m_err;
    assign done    = granted & (m_ack | m_err | ~owner_cyc | timeout);
    assign err_evt = granted & (m_err | timeout);

    riskv_wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (~granted),
        .enable (granted),
        .expire (expire)
    );

    // Read data needs no steering: only the owner sees ack, so the other
    // master ignores whatever appears on its data lines.
    assign i_dat_miso = m_dat_miso;
    assign d_dat_miso = m_dat_miso;

    // Bus-side muxing is combinational so an abort or timeout drops m_cyc
    // in the same cycle.
    always_comb begin
        m_adr      = '0;
        m_sel      = '0;
        m_cyc      = 1'b0;
        m_stb      = 1'b0;
        m_we       = 1'b0;
        m_dat_mosi = '0;
        i_ack      = 1'b0;
        i_err      = 1'b0;
        d_ack      = 1'b0;
        d_err      = 1'b0;
        case (state)
            ST_GNT_I: begin
                m_adr = i_adr;
                m_sel = i_sel;
                m_cyc = i_req & ~timeout;
                m_stb = i_req & ~timeout;
                i_ack = m_ack;
                i_err = m_err | timeout;
            end
            ST_GNT_D: begin
                m_adr      = d_adr;
                m_sel      = d_sel;
                m_we       = d_we;
                m_dat_mosi = d_dat_mosi;
                m_cyc      = d_req & ~timeout;
                m_stb      = d_req & ~timeout;
                d_ack      = m_ack;
                d_err      = m_err | timeout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            grant     <= GNT_NONE;
            last_d    <= 1'b1;
            err_count <= '0;
        end else begin
            if (err_evt && (err_count != {ERRCNT_W{1'b1}})) begin
                err_count <= err_count + ERRCNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    // Fetch wins a tie only when data held the last grant.
                    if (i_req && (!d_req || last_d)) begin
                        state <= ST_GNT_I;
                        grant <= GNT_I;
                    end else if (d_req) begin
                        state <= ST_GNT_D;
                        grant <= GNT_D;
                    end
                end
                ST_GNT_I: begin
                    if (done) begin
                        state  <= ST_IDLE;
                        grant  <= GNT_NONE;
                        last_d <= 1'b0;
                    end
                end
                ST_GNT_D: begin
                    if (done) begin
                        state  <= ST_IDLE;
                        grant  <= GNT_NONE;
                        last_d <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= GNT_NONE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riskv_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_riskv_wb_arbiter
//  Description : Self-checking bench for riskv_wb_arbiter: directed scenarios
//                followed by randomized traffic compared against a simple
//                round-robin/error-count model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_riskv_wb_arbiter;

    localparam int TO     = 16;
    localparam int EW     = 8;
    localparam int ERRMAX = (1 << EW) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] i_adr = '0;
    logic [3:0]  i_sel = '0;
    logic        i_cyc = 1'b0, i_stb = 1'b0;
    logic [31:0] i_dat_miso;
    logic        i_ack, i_err;
    logic [29:0] d_adr = '0;
    logic [31:0] d_dat_mosi = '0;
    logic [3:0]  d_sel = '0;
    logic        d_cyc = 1'b0, d_stb = 1'b0, d_we = 1'b0;
    logic [31:0] d_dat_miso;
    logic        d_ack, d_err;
    logic [29:0] m_adr;
    logic [31:0] m_dat_mosi;
    logic [3:0]  m_sel;
    logic        m_cyc, m_stb, m_we;
    logic [31:0] m_dat_miso = '0;
    logic        m_ack = 1'b0, m_err = 1'b0;
    logic [1:0]  grant;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    riskv_wb_arbiter #(.TIMEOUT_CYCLES(TO), .ERRCNT_W(EW)) dut (
        .clk(clk), .reset(reset),
        .i_adr(i_adr), .i_sel(i_sel), .i_cyc(i_cyc), .i_stb(i_stb),
        .i_dat_miso(i_dat_miso), .i_ack(i_ack), .i_err(i_err),
        .d_adr(d_adr), .d_dat_mosi(d_dat_mosi), .d_sel(d_sel),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we),
        .d_dat_miso(d_dat_miso), .d_ack(d_ack), .d_err(d_err),
        .m_adr(m_adr), .m_dat_mosi(m_dat_mosi), .m_sel(m_sel),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_dat_miso(m_dat_miso), .m_ack(m_ack), .m_err(m_err),
        .grant(grant), .err_count(err_count)
    );

    int total  = 0;
    int passed = 0;

    // Reference model: who owned the bus last, what is outstanding, error tally
    bit last_was_d;
    bit pend_i, pend_d;
    int exp_errs;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic count_err();
        if (exp_errs < ERRMAX) exp_errs++;
    endtask

    task automatic req_i(input logic [29:0] a, input logic [3:0] s);
        i_adr = a; i_sel = s; i_cyc = 1'b1; i_stb = 1'b1; pend_i = 1'b1;
    endtask

    task automatic req_d(input logic [29:0] a, input logic [3:0] s,
                         input logic we, input logic [31:0] dat);
        d_adr = a; d_sel = s; d_we = we; d_dat_mosi = dat;
        d_cyc = 1'b1; d_stb = 1'b1; pend_d = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        i_cyc = 1'b0; i_stb = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
        m_ack = 1'b0; m_err = 1'b0;
        pend_i = 1'b0; pend_d = 1'b0;
        last_was_d = 1'b1;
        exp_errs = 0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Waits for the grant, checks the muxed request, holds it lat cycles,
    // then terminates with the given ack/err and checks the bubble cycle.
    task automatic serve(input int lat, input logic ack, input logic err,
                         input logic [31:0] rdata, output logic [1:0] owner);
        bit own_d;
        int waited;
        own_d  = (pend_i && pend_d) ? !last_was_d : pend_d;
        owner  = own_d ? 2'b10 : 2'b01;
        waited = 0;
        do begin
            tick();
            waited++;
            #1;
        end while (!m_cyc && waited < 4);
        check("arb_latency", waited, 1);
        check("grant", grant, owner);
        check("m_adr", m_adr, own_d ? d_adr : i_adr);
        check("m_sel", m_sel, own_d ? d_sel : i_sel);
        check("m_we", m_we, own_d ? d_we : 1'b0);
        check("m_dat_mosi", m_dat_mosi, own_d ? d_dat_mosi : 32'h0);
        repeat (lat) begin
            check("no_early_term", {i_ack, i_err, d_ack, d_err, m_cyc}, 5'b00001);
            tick();
            #1;
        end
        m_dat_miso = rdata;
        m_ack = ack;
        m_err = err;
        #1;
        check("own_ack", own_d ? d_ack : i_ack, ack);
        check("own_err", own_d ? d_err : i_err, err);
        check("other_term", own_d ? {i_ack, i_err} : {d_ack, d_err}, 2'b00);
        check("dat_miso", own_d ? d_dat_miso : i_dat_miso, rdata);
        check("m_cyc_term_cycle", m_cyc, 1'b1);
        tick();
        m_ack = 1'b0;
        m_err = 1'b0;
        if (own_d) begin d_cyc = 1'b0; d_stb = 1'b0; pend_d = 1'b0; end
        else       begin i_cyc = 1'b0; i_stb = 1'b0; pend_i = 1'b0; end
        last_was_d = own_d;
        if (err) count_err();
        #1;
        check("bubble_m_cyc", m_cyc, 1'b0);
        check("bubble_grant", grant, 2'b00);
        check("err_count", err_count, exp_errs);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] own;
        int waited;

        // ---------------- reset values
        tick();
        reset = 1'b0;
        #1;
        check("rst_grant", grant, 2'b00);
        check("rst_m_cyc", {m_cyc, m_stb, m_we}, 3'b000);
        check("rst_m_bus", {m_adr, m_sel}, 34'h0);
        check("rst_err_count", err_count, 0);
        check("rst_acks", {i_ack, i_err, d_ack, d_err}, 4'h0);
        do_reset();

        // ---------------- single fetch
        req_i(30'h0000100, 4'hF);
        serve(2, 1'b1, 1'b0, 32'h0000_0013, own);
        check("single_fetch_owner", own, 2'b01);

        // ---------------- simultaneous requests after reset, then contention
        do_reset();
        req_i(30'h0000200, 4'hF);
        req_d(30'h0001000, 4'hF, 1'b1, 32'hDEAD_BEEF);
        for (int k = 0; k < 8; k++) begin
            serve(0, 1'b1, 1'b0, 32'h1000 + k, own);
            check("alternate", own, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (own == 2'b01) req_i(30'h0000200 + k, 4'hF);
            else              req_d(30'h0001000 + k, 4'hF, 1'b1, 32'hDEAD_BEEF);
        end
        // drain whichever master is still waiting
        serve(1, 1'b1, 1'b0, 32'h55, own);
        if (pend_i || pend_d) serve(1, 1'b1, 1'b0, 32'h66, own);

        // ---------------- dead slave: data never acked
        req_d(30'h0002000, 4'h3, 1'b0, 32'h0);
        waited = 0;
        do begin tick(); waited++; #1; end while (!m_cyc && waited < 4);
        check("dead_latency", waited, 1);
        for (int c = 1; c < TO; c++) begin
            check("dead_wait", {d_err, m_cyc}, 2'b01);
            tick();
            #1;
        end
        check("dead_d_err", d_err, 1'b1);
        check("dead_forced_low", {m_cyc, m_stb, i_err}, 3'b000);
        tick();
        d_cyc = 1'b0; d_stb = 1'b0; pend_d = 1'b0;
        last_was_d = 1'b1;
        count_err();
        #1;
        check("dead_grant", grant, 2'b00);
        check("dead_err_count", err_count, exp_errs);
        req_i(30'h0000300, 4'hF);
        serve(1, 1'b1, 1'b0, 32'h0000_0093, own);

        // ---------------- abort, then stray terminations in IDLE
        req_i(30'h0000400, 4'hF);
        tick();
        tick();
        i_cyc = 1'b0;
        #1;
        check("abort_m_cyc", {m_cyc, m_stb}, 2'b00);
        tick();
        i_stb = 1'b0; pend_i = 1'b0; last_was_d = 1'b0;
        #1;
        check("abort_grant", grant, 2'b00);
        m_ack = 1'b1;
        m_err = 1'b1;
        #1;
        check("stray_term", {i_ack, i_err, d_ack, d_err}, 4'h0);
        tick();
        m_ack = 1'b0;
        m_err = 1'b0;
        #1;
        check("stray_err_count", err_count, exp_errs);
        check("stray_grant", grant, 2'b00);

        // ---------------- ack+err together; ack in the watchdog expiry cycle
        req_d(30'h0003000, 4'hC, 1'b1, 32'h1234_5678);
        serve(1, 1'b1, 1'b1, 32'hA5A5_A5A5, own);
        req_i(30'h0000500, 4'h1);
        serve(TO - 1, 1'b1, 1'b0, 32'h0BAD_F00D, own);

        // ---------------- randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (!pend_i && $urandom_range(0, 1) == 1)
                req_i(30'($urandom()), 4'($urandom()));
            if (!pend_d && $urandom_range(0, 1) == 1)
                req_d(30'($urandom()), 4'($urandom()), 1'($urandom()), $urandom());
            if (!pend_i && !pend_d)
                req_i(30'($urandom()), 4'($urandom()));
            if ($urandom_range(0, 3) == 0)
                serve($urandom_range(0, 4), 1'b0, 1'b1, $urandom(), own);
            else
                serve($urandom_range(0, 4), 1'b1, 1'b0, $urandom(), own);
        end
        while (pend_i || pend_d) serve(0, 1'b1, 1'b0, 32'h0, own);

        // ---------------- error counter saturation
        do_reset();
        for (int n = 0; n < 260; n++) begin
            req_d(30'(n), 4'hF, 1'b0, 32'h0);
            serve(0, 1'b0, 1'b1, 32'h0, own);
        end
        check("err_saturated", err_count, 8'hFF);

        // ---------------- asynchronous reset mid-transfer
        req_d(30'h3FFF_FFFF, 4'hF, 1'b1, 32'hFFFF_FFFF);
        tick();
        tick();
        #1;
        check("pre_reset_m_cyc", m_cyc, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_m_ctl", {m_cyc, m_stb, m_we}, 3'b000);
        check("mid_rst_m_adr", m_adr, 30'h0);
        check("mid_rst_m_sel", m_sel, 4'h0);
        check("mid_rst_m_mosi", m_dat_mosi, 32'h0);
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_err_count", err_count, 0);
        d_cyc = 1'b0; d_stb = 1'b0; pend_d = 1'b0;
        m_ack = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        last_was_d = 1'b1;
        exp_errs = 0;
        tick();
        #1;
        check("post_rst_pending_ack", {i_ack, d_ack, m_cyc}, 3'b000);
        check("post_rst_grant", grant, 2'b00);
        check("post_rst_err_count", err_count, 0);
        m_ack = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
